pll_lock_sequencer: RTL and testbench

//  Controls SB_PLL40 bring-up and recovery. Runs on the raw reference clock (clock_in).
//  - Drives the PLL RESETB/BYPASS pins.
//  - Qualifies the asynchronous LOCK output.
//  - Holds the system reset until lock has been stable for a set time.
//  - Retries a PLL that fails to lock; after MAX_RETRIES failures, falls back to bypass.

---
 rtl/pll_seq_pkg.sv | 52 +++++
 rtl/sync_ff.sv | 20 ++
 rtl/pll_lock_sequencer.sv | 136 +++++++++++++
 tb/tb_pll_lock_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL lock sequencer: state encoding, output bundle,
// and the timer width calculation.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } pll_state_e;

  localparam int unsigned LOSS_W = 8;

  typedef struct packed {
    logic pll_resetb;
    logic pll_bypass;
    logic sys_rst_n;
    logic fail;
  } pll_out_t;

  // Width of a down-counter able to hold the largest of the three cycle counts.
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

  // Output pin values while resident in a state; illegal encodings look like PLL_RST.
  function automatic pll_out_t state_outputs(input pll_state_e st);
    pll_out_t o;
    o = '0;
    case (st)
      ST_WAIT_LOCK, ST_STABLE: o.pll_resetb = 1'b1;
      ST_RUN: begin
        o.pll_resetb = 1'b1;
        o.sys_rst_n  = 1'b1;
      end
      ST_FAIL: begin
        o.pll_bypass = 1'b1;
        o.sys_rst_n  = 1'b1;
        o.fail       = 1'b1;
      end
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Generic multi-flop synchronizer for a single asynchronous bit, async active-low reset.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// SB_PLL40 bring-up/recovery sequencer: drives RESETB/BYPASS, qualifies LOCK, gates the
// system reset, retries failed lock attempts and falls back to bypass.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned PLL_RST_CYCLES     = 16,
  parameter int unsigned LOCK_TIMEOUT       = 1200,
  parameter int unsigned LOCK_STABLE_CYCLES = 256,
  parameter int unsigned MAX_RETRIES        = 3
) (
  input  logic              clock_in,
  input  logic              resetb,
  input  logic              pll_locked,
  input  logic              restart_req,
  output logic              pll_resetb,
  output logic              pll_bypass,
  output logic              sys_rst_n,
  output logic              fail,
  output logic [2:0]        state_o,
  output logic [LOSS_W-1:0] loss_count
);

  localparam int unsigned TW = timer_width(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE_CYCLES);
  localparam int unsigned RW = $clog2(MAX_RETRIES + 1);

  localparam logic [TW-1:0] RST_LOAD    = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STABLE_LOAD = TW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RW-1:0] MAX_R       = RW'(MAX_RETRIES);

  logic              lock_s;
  pll_state_e        state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [RW-1:0]     retries_q, retries_d, retries_inc;
  logic [LOSS_W-1:0] loss_q, loss_d;
  pll_out_t          out_q;
  logic              timer_done;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk  (clock_in),
    .rst_n(resetb),
    .d    (pll_locked),
    .q    (lock_s)
  );

  assign timer_done  = (timer_q == '0);
  assign retries_inc = retries_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    retries_d = retries_q;
    loss_d    = loss_q;
    if (restart_req) begin
      state_d   = ST_PLL_RST;
      timer_d   = RST_LOAD;
      retries_d = '0;
    end else begin
      case (state_q)
        ST_PLL_RST: begin
          if (timer_done) begin
            state_d = ST_WAIT_LOCK;
            timer_d = TIMEOUT_LOAD;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          // Lock arriving on the timeout edge still counts as success.
          if (lock_s) begin
            state_d = ST_STABLE;
            timer_d = STABLE_LOAD;
          end else if (timer_done) begin
            retries_d = retries_inc;
            timer_d   = RST_LOAD;
            state_d   = (retries_inc == MAX_R) ? ST_FAIL : ST_PLL_RST;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            timer_d = TIMEOUT_LOAD;
          end else if (timer_done) begin
            state_d   = ST_RUN;
            retries_d = '0;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_d = ST_PLL_RST;
            timer_d = RST_LOAD;
            if (loss_q != '1) loss_d = loss_q + 1'b1;
          end
        end
        ST_FAIL: ;
        default: begin
          state_d   = ST_PLL_RST;
          timer_d   = RST_LOAD;
          retries_d = '0;
        end
      endcase
    end
  end

  // Pins are decoded from the next state so every output comes straight off a flop.
  always_ff @(posedge clock_in or negedge resetb) begin
    if (!resetb) begin
      state_q   <= ST_PLL_RST;
      timer_q   <= RST_LOAD;
      retries_q <= '0;
      loss_q    <= '0;
      out_q     <= state_outputs(ST_PLL_RST);
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retries_q <= retries_d;
      loss_q    <= loss_d;
      out_q     <= state_outputs(state_d);
    end
  end

  assign pll_resetb = out_q.pll_resetb;
  assign pll_bypass = out_q.pll_bypass;
  assign sys_rst_n  = out_q.sys_rst_n;
  assign fail       = out_q.fail;
  assign state_o    = state_q;
  assign loss_count = loss_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: expectations are queued with a target cycle when
// stimulus is applied and compared on the falling edge of that cycle.
module tb_pll_lock_sequencer;

  localparam int F_STATE  = 0;
  localparam int F_RESETB = 1;
  localparam int F_BYPASS = 2;
  localparam int F_SYSRST = 3;
  localparam int F_FAIL   = 4;
  localparam int F_LOSS   = 5;

  logic       clock_in    = 1'b0;
  logic       resetb      = 1'b0;
  logic       pll_locked  = 1'b0;
  logic       restart_req = 1'b0;
  logic       pll_resetb, pll_bypass, sys_rst_n, fail;
  logic [2:0] state_o;
  logic [7:0] loss_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int loss_exp = 0;
  int b;

  typedef struct {
    int    at;
    int    sel;
    int    val;
    string tag;
  } exp_t;
  exp_t sb[$];

  pll_lock_sequencer #(
    .SYNC_STAGES       (2),
    .PLL_RST_CYCLES    (4),
    .LOCK_TIMEOUT      (20),
    .LOCK_STABLE_CYCLES(8),
    .MAX_RETRIES       (3)
  ) dut (
    .clock_in   (clock_in),
    .resetb     (resetb),
    .pll_locked (pll_locked),
    .restart_req(restart_req),
    .pll_resetb (pll_resetb),
    .pll_bypass (pll_bypass),
    .sys_rst_n  (sys_rst_n),
    .fail       (fail),
    .state_o    (state_o),
    .loss_count (loss_count)
  );

  always #5 clock_in = ~clock_in;

  // cyc = number of rising edges since reset was released.
  always @(posedge clock_in or negedge resetb) begin
    if (!resetb) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      F_STATE:  return {29'd0, state_o};
      F_RESETB: return {31'd0, pll_resetb};
      F_BYPASS: return {31'd0, pll_bypass};
      F_SYSRST: return {31'd0, sys_rst_n};
      F_FAIL:   return {31'd0, fail};
      default:  return {24'd0, loss_count};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic expect_at(input int dc, input string tag, input int sel, input int val);
    exp_t e;
    e.at  = cyc + dc;
    e.sel = sel;
    e.val = val;
    e.tag = tag;
    sb.push_back(e);
  endtask

  always @(negedge clock_in) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        check(sb[i].tag, observe(sb[i].sel), sb[i].val);
        sb.delete(i);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock_in);
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge clock_in);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    step(3);
    check("rst_state", state_o, 0);
    check("rst_pll_resetb", pll_resetb, 0);
    check("rst_bypass", pll_bypass, 0);
    check("rst_sys_rst_n", sys_rst_n, 0);
    check("rst_fail", fail, 0);
    check("rst_loss", loss_count, 0);

    // 1: release, lock sampled at cycle 10
    resetb = 1'b1;
    expect_at(3, "t1_resetb_low", F_RESETB, 0);
    expect_at(4, "t1_resetb_rise", F_RESETB, 1);
    expect_at(4, "t1_wait", F_STATE, 1);
    expect_at(11, "t1_wait11", F_STATE, 1);
    expect_at(12, "t1_stable", F_STATE, 2);
    expect_at(19, "t1_sys_held", F_SYSRST, 0);
    expect_at(20, "t1_run", F_STATE, 3);
    expect_at(20, "t1_sys_rel", F_SYSRST, 1);
    goto(9);
    pll_locked = 1'b1;
    goto(20);

    // 3: one-cycle lock loss in RUN
    b = cyc;
    loss_exp = 1;
    expect_at(2, "t3_sys_still", F_SYSRST, 1);
    expect_at(3, "t3_sys_drop", F_SYSRST, 0);
    expect_at(3, "t3_pll_rst", F_STATE, 0);
    expect_at(3, "t3_loss", F_LOSS, loss_exp);
    expect_at(7, "t3_wait", F_STATE, 1);
    expect_at(8, "t3_stable", F_STATE, 2);
    expect_at(15, "t3_sys_held", F_SYSRST, 0);
    expect_at(16, "t3_run", F_STATE, 3);
    expect_at(16, "t3_sys_rel", F_SYSRST, 1);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    goto(b + 16);

    // 4: glitch at stable cycle 5
    b = cyc;
    expect_at(1, "t4_restart", F_STATE, 0);
    expect_at(1, "t4_loss_kept", F_LOSS, loss_exp);
    expect_at(5, "t4_wait", F_STATE, 1);
    expect_at(6, "t4_stable", F_STATE, 2);
    expect_at(12, "t4_stable12", F_STATE, 2);
    expect_at(13, "t4_back_wait", F_STATE, 1);
    expect_at(13, "t4_sys_held", F_SYSRST, 0);
    expect_at(14, "t4_restable", F_STATE, 2);
    expect_at(21, "t4_sys_not_early", F_SYSRST, 0);
    expect_at(22, "t4_run", F_STATE, 3);
    expect_at(22, "t4_sys_rel", F_SYSRST, 1);
    restart_req = 1'b1;
    step(1);
    restart_req = 1'b0;
    goto(b + 10);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    goto(b + 22);

    // 2: lock never arrives -> three rounds then FAIL
    b = cyc;
    expect_at(1, "t2_pll_rst", F_STATE, 0);
    expect_at(5, "t2_wait1", F_STATE, 1);
    expect_at(5, "t2_resetb1", F_RESETB, 1);
    expect_at(24, "t2_wait1_end", F_STATE, 1);
    expect_at(25, "t2_retry1", F_STATE, 0);
    expect_at(25, "t2_resetb_low", F_RESETB, 0);
    expect_at(48, "t2_wait2_end", F_STATE, 1);
    expect_at(49, "t2_retry2", F_STATE, 0);
    expect_at(72, "t2_wait3_end", F_STATE, 1);
    expect_at(72, "t2_not_fail", F_FAIL, 0);
    expect_at(73, "t2_fail_state", F_STATE, 4);
    expect_at(73, "t2_fail", F_FAIL, 1);
    expect_at(73, "t2_bypass", F_BYPASS, 1);
    expect_at(73, "t2_sys_run", F_SYSRST, 1);
    expect_at(73, "t2_resetb", F_RESETB, 0);
    expect_at(73, "t2_loss_kept", F_LOSS, loss_exp);
    pll_locked  = 1'b0;
    restart_req = 1'b1;
    step(1);
    restart_req = 1'b0;
    goto(b + 76);
    check("t2_fail_holds", state_o, 4);

    // 5: restart out of FAIL with lock present
    b = cyc;
    expect_at(1, "t5_pll_rst", F_STATE, 0);
    expect_at(1, "t5_fail_clr", F_FAIL, 0);
    expect_at(1, "t5_bypass_clr", F_BYPASS, 0);
    expect_at(1, "t5_sys_held", F_SYSRST, 0);
    expect_at(5, "t5_wait", F_STATE, 1);
    expect_at(6, "t5_stable", F_STATE, 2);
    expect_at(14, "t5_run", F_STATE, 3);
    expect_at(14, "t5_sys_rel", F_SYSRST, 1);
    pll_locked  = 1'b1;
    restart_req = 1'b1;
    step(1);
    restart_req = 1'b0;
    goto(b + 14);

    // 256 forced losses, count saturates
    for (int k = 0; k < 256; k++) begin
      b = cyc;
      loss_exp = (loss_exp < 255) ? loss_exp + 1 : 255;
      expect_at(3, "t5_loss", F_LOSS, loss_exp);
      expect_at(16, "t5_rerun", F_STATE, 3);
      pll_locked = 1'b0;
      step(1);
      pll_locked = 1'b1;
      goto(b + 16);
    end
    check("t5_loss_sat", loss_count, 255);

    // Lock rising on WAIT_LOCK timeout edge, then lock falling on STABLE timeout edge
    b = cyc;
    expect_at(24, "bd_wait_last", F_STATE, 1);
    expect_at(25, "bd_lock_wins", F_STATE, 2);
    expect_at(32, "bd_stable_last", F_STATE, 2);
    expect_at(33, "bd_drop_wins", F_STATE, 1);
    expect_at(33, "bd_sys_held", F_SYSRST, 0);
    expect_at(34, "bd_restable", F_STATE, 2);
    expect_at(41, "bd_sys_held2", F_SYSRST, 0);
    expect_at(42, "bd_run", F_STATE, 3);
    expect_at(42, "bd_sys_rel", F_SYSRST, 1);
    pll_locked  = 1'b0;
    restart_req = 1'b1;
    step(1);
    restart_req = 1'b0;
    goto(b + 22);
    pll_locked = 1'b1;
    goto(b + 30);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    goto(b + 42);

    // 6: async reset mid-STABLE
    b = cyc;
    expect_at(8, "t6_stable", F_STATE, 2);
    expect_at(8, "t6_resetb_hi", F_RESETB, 1);
    restart_req = 1'b1;
    step(1);
    restart_req = 1'b0;
    goto(b + 9);
    #2 resetb = 1'b0;
    #1;
    check("t6_state", state_o, 0);
    check("t6_pll_resetb", pll_resetb, 0);
    check("t6_bypass", pll_bypass, 0);
    check("t6_sys_rst_n", sys_rst_n, 0);
    check("t6_fail", fail, 0);
    check("t6_loss", loss_count, 0);
    step(2);
    resetb = 1'b1;
    expect_at(3, "t6_rel_resetb_low", F_RESETB, 0);
    expect_at(4, "t6_rel_resetb_rise", F_RESETB, 1);
    goto(5);

    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
